// File: rtl/pwm_pkg.sv
// Shared definitions for the RGB breathing sequencer: FSM state codes,
// channel indices and the channel-rotation helpers.
package pwm_pkg;

  localparam int PWM_W_DEF = 8;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] UP   = 2'd1;
  localparam logic [1:0] DOWN = 2'd2;
  localparam logic [1:0] NEXT = 2'd3;

  localparam logic [1:0] CH_R = 2'd0;
  localparam logic [1:0] CH_G = 2'd1;
  localparam logic [1:0] CH_B = 2'd2;

  typedef struct packed {
    logic       wrap;
    logic [1:0] idx;
  } chan_step_t;

  function automatic logic [1:0] first_chan(input logic [2:0] mask);
    logic [1:0] idx;
    if (mask[0]) begin
      idx = CH_R;
    end else if (mask[1]) begin
      idx = CH_G;
    end else begin
      idx = CH_B;
    end
    return idx;
  endfunction

  // Next enabled channel in R->G->B order; wrap marks the end of a full pass.
  function automatic chan_step_t next_chan(input logic [2:0] mask, input logic [1:0] cur);
    chan_step_t r;
    r.wrap = 1'b0;
    r.idx  = first_chan(mask);
    case (cur)
      CH_R: begin
        if (mask[1]) begin
          r.idx = CH_G;
        end else if (mask[2]) begin
          r.idx = CH_B;
        end else begin
          r.wrap = 1'b1;
        end
      end
      CH_G: begin
        if (mask[2]) begin
          r.idx = CH_B;
        end else begin
          r.wrap = 1'b1;
        end
      end
      default: r.wrap = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/breath_prescaler.sv
// Ramp-step prescaler: counts 0..div-1 and flags the last count as a step tick.
// A divider of zero behaves as a divider of one.
module breath_prescaler #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] div,
  input  logic             clear,
  output logic             step_tick
);

  logic [DIV_W-1:0] count_r;
  logic [DIV_W-1:0] div_eff_s;

  assign div_eff_s = (div == {DIV_W{1'b0}}) ? {{(DIV_W-1){1'b0}}, 1'b1} : div;
  assign step_tick = (count_r == (div_eff_s - {{(DIV_W-1){1'b0}}, 1'b1}));

  // Step counter; clear restarts the spacing so the first step is a full period away.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= {DIV_W{1'b0}};
    end else if (clear || step_tick) begin
      count_r <= {DIV_W{1'b0}};
    end else begin
      count_r <= count_r + {{(DIV_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/rgb_breath_sequencer.sv
// Breathing-LED sequencer: triangle duty ramp applied to each enabled RGB
// channel in turn, with a registered PWM comparator and idle-time config load.
module rgb_breath_sequencer
  import pwm_pkg::*;
#(
  parameter int               PWM_W       = PWM_W_DEF,
  parameter int               DIV_W       = 16,
  parameter logic [DIV_W-1:0] DEFAULT_DIV = 16'd1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic [2:0]       cfg_mask,
  output logic [2:0]       pwm_out,
  output logic [PWM_W-1:0] duty,
  output logic [1:0]       chan,
  output logic             busy,
  output logic             seq_done
);

  localparam logic [PWM_W-1:0] DUTY_ZERO = {PWM_W{1'b0}};
  localparam logic [PWM_W-1:0] DUTY_ONE  = {{(PWM_W-1){1'b0}}, 1'b1};
  localparam logic [PWM_W-1:0] DUTY_MAX  = {PWM_W{1'b1}};
  localparam logic [PWM_W-1:0] DUTY_TURN = {{(PWM_W-1){1'b1}}, 1'b0};

  logic [1:0]       state_r;
  logic [PWM_W-1:0] duty_r;
  logic [1:0]       chan_r;
  logic             seq_done_r;
  logic [2:0]       pwm_out_r;
  logic [PWM_W-1:0] pwm_cnt_r;
  logic [DIV_W-1:0] div_r;
  logic [2:0]       mask_r;

  logic             step_tick_s;
  logic             start_s;
  logic             clear_s;
  logic [2:0]       chan_bit_s;
  chan_step_t       step_s;

  assign cfg_ready  = (state_r == IDLE);
  assign busy       = (state_r != IDLE);
  assign duty       = duty_r;
  assign chan       = chan_r;
  assign seq_done   = seq_done_r;
  assign pwm_out    = pwm_out_r;

  assign start_s    = (state_r == IDLE) && en && (mask_r != 3'b000);
  assign clear_s    = start_s || ((state_r == NEXT) && en);
  assign step_s     = next_chan(mask_r, chan_r);
  assign chan_bit_s = 3'b001 << chan_r;

  breath_prescaler #(
    .DIV_W(DIV_W)
  ) u_prescaler (
    .clk      (clk),
    .rst      (rst),
    .div      (div_r),
    .clear    (clear_s),
    .step_tick(step_tick_s)
  );

  // Configuration registers, writable only while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_r  <= DEFAULT_DIV;
      mask_r <= 3'b111;
    end else if (cfg_valid && cfg_ready) begin
      div_r  <= cfg_div;
      mask_r <= cfg_mask;
    end else begin
      div_r  <= div_r;
      mask_r <= mask_r;
    end
  end

  // Ramp FSM, channel rotation and pass-complete pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      duty_r     <= DUTY_ZERO;
      chan_r     <= CH_R;
      seq_done_r <= 1'b0;
    end else if (!en) begin
      state_r    <= IDLE;
      duty_r     <= DUTY_ZERO;
      seq_done_r <= 1'b0;
    end else begin
      seq_done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (mask_r != 3'b000) begin
            state_r <= UP;
            chan_r  <= first_chan(mask_r);
          end
          duty_r <= DUTY_ZERO;
        end
        UP: begin
          if (step_tick_s) begin
            if (duty_r == DUTY_TURN) begin
              duty_r  <= DUTY_MAX;
              state_r <= DOWN;
            end else begin
              duty_r <= duty_r + DUTY_ONE;
            end
          end
        end
        DOWN: begin
          if (step_tick_s) begin
            if (duty_r == DUTY_ONE) begin
              duty_r     <= DUTY_ZERO;
              state_r    <= NEXT;
              // Raised for the NEXT cycle itself when this channel ends the pass.
              seq_done_r <= step_s.wrap;
            end else begin
              duty_r <= duty_r - DUTY_ONE;
            end
          end
        end
        NEXT: begin
          chan_r  <= step_s.idx;
          state_r <= UP;
        end
        default: begin
          state_r <= IDLE;
          duty_r  <= DUTY_ZERO;
        end
      endcase
    end
  end

  // Free-running PWM counter and registered compare onto the active pin.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_cnt_r <= DUTY_ZERO;
      pwm_out_r <= 3'b000;
    end else begin
      pwm_cnt_r <= pwm_cnt_r + DUTY_ONE;
      // Dropping en blanks the pins on the same edge that discards the ramp.
      if (en && (pwm_cnt_r < duty_r)) begin
        pwm_out_r <= chan_bit_s;
      end else begin
        pwm_out_r <= 3'b000;
      end
    end
  end

endmodule

// File: tb/tb_rgb_breath_sequencer.sv
// Directed bench for rgb_breath_sequencer: a single-cycle vector table for
// reset/config/start behaviour, then hand-written multi-cycle ramp sequences.
module tb_rgb_breath_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [15:0] cfg_div = 16'd0;
  logic [2:0]  cfg_mask = 3'b000;
  logic [2:0]  pwm_out;
  logic [7:0]  duty;
  logic [1:0]  chan;
  logic        busy;
  logic        seq_done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rst;
    logic        en;
    logic        valid;
    logic [15:0] div;
    logic [2:0]  mask;
    logic        exp_busy;
    logic        exp_ready;
    logic [7:0]  exp_duty;
    logic [1:0]  exp_chan;
    logic        chk_pwm;
  } vec_t;

  vec_t tbl[17];

  rgb_breath_sequencer dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_div  (cfg_div),
    .cfg_mask (cfg_mask),
    .pwm_out  (pwm_out),
    .duty     (duty),
    .chan     (chan),
    .busy     (busy),
    .seq_done (seq_done)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic set_vec(input int i, input logic r, input logic e, input logic v,
                         input logic [15:0] d, input logic [2:0] m, input logic b,
                         input logic rd, input logic [7:0] du, input logic [1:0] c,
                         input logic cp);
    tbl[i].rst = r;       tbl[i].en = e;         tbl[i].valid = v;
    tbl[i].div = d;       tbl[i].mask = m;       tbl[i].exp_busy = b;
    tbl[i].exp_ready = rd; tbl[i].exp_duty = du; tbl[i].exp_chan = c;
    tbl[i].chk_pwm = cp;
  endtask

  task automatic load_cfg(input logic [15:0] d, input logic [2:0] m);
    cfg_valid = 1'b1; cfg_div = d; cfg_mask = m;
    tick;
    cfg_valid = 1'b0;
  endtask

  task automatic wait_duty(input logic [7:0] target, input int bound, inout int n);
    int k;
    k = 0;
    while (duty !== target && k < bound) begin
      tick;
      k++;
      n++;
    end
  endtask

  initial begin
    int n, bad, changes, pulses, highs;
    logic [1:0] prev_chan, pulse_chan;

    //          rst   en    valid div     mask    busy  ready duty  chan  chkpwm
    set_vec(0,  1'b1, 1'b0, 1'b0, 16'd0,  3'b000, 1'b0, 1'b1, 8'd0, 2'd0, 1'b1);
    set_vec(1,  1'b0, 1'b0, 1'b0, 16'd0,  3'b000, 1'b0, 1'b1, 8'd0, 2'd0, 1'b1);
    set_vec(2,  1'b0, 1'b1, 1'b0, 16'd0,  3'b000, 1'b1, 1'b0, 8'd0, 2'd0, 1'b1);
    set_vec(3,  1'b0, 1'b1, 1'b1, 16'd5,  3'b010, 1'b1, 1'b0, 8'd0, 2'd0, 1'b1);
    set_vec(4,  1'b0, 1'b0, 1'b0, 16'd0,  3'b000, 1'b0, 1'b1, 8'd0, 2'd0, 1'b1);
    set_vec(5,  1'b0, 1'b0, 1'b1, 16'd0,  3'b000, 1'b0, 1'b1, 8'd0, 2'd0, 1'b1);
    set_vec(6,  1'b0, 1'b1, 1'b0, 16'd0,  3'b000, 1'b0, 1'b1, 8'd0, 2'd0, 1'b1);
    set_vec(7,  1'b0, 1'b1, 1'b0, 16'd0,  3'b000, 1'b0, 1'b1, 8'd0, 2'd0, 1'b1);
    set_vec(8,  1'b0, 1'b0, 1'b1, 16'd0,  3'b100, 1'b0, 1'b1, 8'd0, 2'd0, 1'b1);
    set_vec(9,  1'b0, 1'b1, 1'b0, 16'd0,  3'b000, 1'b1, 1'b0, 8'd0, 2'd2, 1'b1);
    set_vec(10, 1'b0, 1'b1, 1'b0, 16'd0,  3'b000, 1'b1, 1'b0, 8'd1, 2'd2, 1'b1);
    set_vec(11, 1'b0, 1'b1, 1'b0, 16'd0,  3'b000, 1'b1, 1'b0, 8'd2, 2'd2, 1'b0);
    set_vec(12, 1'b0, 1'b0, 1'b0, 16'd0,  3'b000, 1'b0, 1'b1, 8'd0, 2'd2, 1'b1);
    set_vec(13, 1'b0, 1'b1, 1'b1, 16'd3,  3'b011, 1'b1, 1'b0, 8'd0, 2'd2, 1'b1);
    set_vec(14, 1'b0, 1'b0, 1'b0, 16'd0,  3'b000, 1'b0, 1'b1, 8'd0, 2'd2, 1'b1);
    set_vec(15, 1'b0, 1'b1, 1'b0, 16'd0,  3'b000, 1'b1, 1'b0, 8'd0, 2'd0, 1'b1);
    set_vec(16, 1'b0, 1'b0, 1'b0, 16'd0,  3'b000, 1'b0, 1'b1, 8'd0, 2'd0, 1'b1);

    for (int i = 0; i < 17; i++) begin
      rst = tbl[i].rst; en = tbl[i].en; cfg_valid = tbl[i].valid;
      cfg_div = tbl[i].div; cfg_mask = tbl[i].mask;
      tick;
      check($sformatf("vec%0d_state", i),
            {busy, cfg_ready, duty, chan, (tbl[i].chk_pwm ? pwm_out : 3'b000), seq_done},
            {tbl[i].exp_busy, tbl[i].exp_ready, tbl[i].exp_duty, tbl[i].exp_chan, 3'b000, 1'b0});
    end
    cfg_valid = 1'b0;

    // Single red channel, div=2: full up/down ramp timing and pass pulse.
    load_cfg(16'd2, 3'b001);
    en = 1'b1;
    tick;
    n = 0; bad = 0;
    while (duty !== 8'd255 && n < 2000) begin
      tick; n++;
      if (pwm_out[2:1] !== 2'b00) bad++;
    end
    check("A_up_cycles", n, 510);
    while (seq_done !== 1'b1 && n < 3000) begin
      tick; n++;
      if (pwm_out[2:1] !== 2'b00) bad++;
    end
    check("A_done_cycles", n, 1020);
    check("A_next_outputs", {busy, duty, chan}, {1'b1, 8'd0, 2'd0});
    tick;
    check("A_after_next", {seq_done, busy, chan}, {1'b0, 1'b1, 2'd0});
    check("A_gb_pins_low", bad, 0);

    // R+B mask, div=1: channel rotation 0,2,0,2 with one pulse on the 2->0 wrap.
    en = 1'b0;
    tick;
    load_cfg(16'd1, 3'b101);
    en = 1'b1;
    tick;
    check("B_start_chan", chan, 0);
    prev_chan = chan; changes = 0; pulses = 0; pulse_chan = 2'd3; bad = 0;
    for (int k = 0; k < 1540; k++) begin
      tick;
      if (chan !== prev_chan) changes++;
      prev_chan = chan;
      if (seq_done === 1'b1) begin
        pulses++;
        pulse_chan = chan;
      end
      if (pwm_out[1] !== 1'b0) bad++;
    end
    check("B_chan_changes", changes, 3);
    check("B_pulses", pulses, 1);
    check("B_pulse_chan", pulse_chan, 2);
    check("B_final_chan", chan, 2);
    check("B_g_pin_low", bad, 0);

    // Green only, div=300: busy config offer ignored, PWM duty-cycle counts.
    en = 1'b0;
    tick;
    load_cfg(16'd300, 3'b010);
    en = 1'b1;
    tick;
    n = 0;
    cfg_valid = 1'b1; cfg_div = 16'd1; cfg_mask = 3'b100;
    check("C_ready_busy", cfg_ready, 0);
    tick; n++;
    cfg_valid = 1'b0;
    wait_duty(8'd10, 4000, n);
    check("C_step_spacing", n, 3000);
    check("C_chan_kept", chan, 1);
    tick; tick;
    highs = 0; bad = 0;
    for (int k = 0; k < 256; k++) begin
      tick;
      if (pwm_out[1] === 1'b1) highs++;
      if ({pwm_out[2], pwm_out[0]} !== 2'b00) bad++;
    end
    check("C_pwm_10", highs, 10);
    n = 0;
    wait_duty(8'd128, 40000, n);
    check("C_reach_128", duty, 128);
    tick; tick;
    highs = 0;
    for (int k = 0; k < 256; k++) begin
      tick;
      if (pwm_out[1] === 1'b1) highs++;
      if ({pwm_out[2], pwm_out[0]} !== 2'b00) bad++;
    end
    check("C_pwm_128", highs, 128);
    check("C_other_pins", bad, 0);

    // Idle: duty 0 never drives a pin; new divider changes step spacing.
    en = 1'b0;
    tick;
    check("E_idle_busy", busy, 0);
    highs = 0;
    for (int k = 0; k < 256; k++) begin
      tick;
      if (pwm_out !== 3'b000) highs++;
    end
    check("E_pwm_duty0", highs, 0);
    load_cfg(16'd3, 3'b011);
    en = 1'b1;
    tick;
    n = 0;
    wait_duty(8'd1, 100, n);
    check("E_first_step", n, 3);
    wait_duty(8'd2, 100, n);
    check("E_second_step", n, 6);

    // Drop en mid-DOWN at duty 77.
    n = 0;
    wait_duty(8'd255, 2000, n);
    check("D_reach_255", duty, 255);
    wait_duty(8'd77, 2000, n);
    check("D_reach_77", duty, 77);
    en = 1'b0;
    tick;
    check("D_abort", {busy, cfg_ready, duty, pwm_out}, {1'b0, 1'b1, 8'd0, 3'b000});

    // Asynchronous reset mid-ramp restores reset state and default mask.
    load_cfg(16'd2, 3'b100);
    en = 1'b1;
    tick;
    check("F_start_chan", chan, 2);
    for (int k = 0; k < 6; k++) tick;
    #3 rst = 1'b1;
    #1;
    check("F_async_reset", {busy, cfg_ready, duty, chan, pwm_out, seq_done},
          {1'b0, 1'b1, 8'd0, 2'd0, 3'b000, 1'b0});
    tick;
    rst = 1'b0;
    tick;
    check("F_default_mask", {busy, chan}, {1'b1, 2'd0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
